// File: rtl/apb_result_completer.sv
// rtl/apb_result_completer.sv - APB completer buffering ALU result words in a K-deep FIFO
// Register map: 0 DATA (push/peek), 1 POP, 2 STATUS, 3 CTRL (flush/clear stickies).
module apb_result_completer #(
  parameter int M           = 8,
  parameter int K           = 8,
  parameter int WAIT_STATES = 0,
  parameter int SLAVE_ID    = 0
) (
  input  logic         PCLK,
  input  logic         PRESET,
  input  logic [1:0]   PADDR,
  input  logic [1:0]   PSELx,
  input  logic         PENABLE,
  input  logic         PWRITE,
  input  logic [M-1:0] PWDATA,
  output logic         PREADY,
  output logic [M-1:0] PRDATA,
  output logic         PSLVERR,
  output logic [3:0]   o_count,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_irq
);

  localparam int AW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t         state_q, state_d;
  logic [3:0]     wait_q, wait_d;
  logic [M-1:0]   mem_q [K];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [3:0]     count_q;
  logic           ovf_q, udf_q;
  logic           sel, commit, push;
  logic           empty, full;
  logic [M-1:0]   head, rdata_c;
  logic [7:0]     status;
  logic           err_c;
  logic           sel_unused;

  assign sel        = PSELx[SLAVE_ID];
  assign sel_unused = ^PSELx;
  assign empty      = (count_q == 4'd0);
  assign full       = (count_q == 4'(K));
  assign head       = mem_q[rd_ptr_q];
  assign status     = {udf_q, ovf_q, full, empty, count_q};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    PREADY  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel && !PENABLE) begin
          state_d = S_ACCESS;
          wait_d  = 4'(WAIT_STATES);
        end
      end
      S_ACCESS: begin
        PREADY = (wait_q == 4'd0);
        if (!sel) begin
          state_d = S_IDLE;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else if (PENABLE) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response decode is purely from registered FIFO state and the current address/direction.
  always_comb begin
    rdata_c = '0;
    err_c   = 1'b0;
    case (PADDR)
      2'd0: begin
        if (PWRITE) err_c = full;
        else if (!empty) rdata_c = head;
      end
      2'd1: begin
        if (PWRITE || empty) err_c = 1'b1;
        else rdata_c = head;
      end
      2'd2: begin
        if (PWRITE) err_c = 1'b1;
        else rdata_c[7:0] = status;
      end
      default: ;
    endcase
  end

  assign PRDATA  = (PREADY && !PWRITE) ? rdata_c : '0;
  assign PSLVERR = PREADY ? err_c : 1'b0;
  assign push    = commit && PWRITE && (PADDR == 2'd0) && !full;

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q  <= S_IDLE;
      wait_q   <= 4'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (commit) begin
        case (PADDR)
          2'd0: begin
            if (PWRITE) begin
              if (full) begin
                ovf_q <= 1'b1;
              end else begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_q + 4'd1;
              end
            end
          end
          2'd1: begin
            if (!PWRITE) begin
              if (empty) begin
                udf_q <= 1'b1;
              end else begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q  <= count_q - 4'd1;
              end
            end
          end
          2'd3: begin
            if (PWRITE && PWDATA[0]) begin
              rd_ptr_q <= '0;
              wr_ptr_q <= '0;
              count_q  <= 4'd0;
            end
            if (PWRITE && PWDATA[1]) begin
              ovf_q <= 1'b0;
              udf_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Storage carries no reset; contents are only visible through count-qualified reads.
  always_ff @(posedge PCLK) begin
    if (push) mem_q[wr_ptr_q] <= PWDATA;
  end

  assign o_count = count_q;
  assign o_empty = empty;
  assign o_full  = full;
  assign o_irq   = !empty;

endmodule

// File: tb/tb_apb_result_completer.sv
// tb/tb_apb_result_completer.sv - self-checking bench: vector table, random model compare, corner sequences
module tb_apb_result_completer;
  localparam int K = 8;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b0;
  logic [1:0] PADDR = '0;
  logic [1:0] PSELx = '0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PWDATA = '0;

  logic       ready0, err0, empty0, full0, irq0;
  logic [7:0] rdata0;
  logic [3:0] count0;
  logic       ready1, err1, empty1, full1, irq1;
  logic [7:0] rdata1;
  logic [3:0] count1;

  apb_result_completer #(.M(8), .K(K), .WAIT_STATES(0), .SLAVE_ID(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(ready0), .PRDATA(rdata0), .PSLVERR(err0),
    .o_count(count0), .o_empty(empty0), .o_full(full0), .o_irq(irq0));

  apb_result_completer #(.M(8), .K(K), .WAIT_STATES(3), .SLAVE_ID(1)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(ready1), .PRDATA(rdata1), .PSLVERR(err1),
    .o_count(count1), .o_empty(empty1), .o_full(full1), .o_irq(irq1));

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  logic       cur = 1'b0;
  logic       rdy_m, err_m, empty_m, full_m, irq_m;
  logic [7:0] rdata_m;
  logic [3:0] count_m;
  assign rdy_m   = cur ? ready1 : ready0;
  assign err_m   = cur ? err1 : err0;
  assign rdata_m = cur ? rdata1 : rdata0;
  assign count_m = cur ? count1 : count0;
  assign empty_m = cur ? empty1 : empty0;
  assign full_m  = cur ? full1 : full0;
  assign irq_m   = cur ? irq1 : irq0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         ovf[2];
  bit         udf[2];

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    bit         exp_err;
  } vec_t;
  vec_t tv[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model(input int sid, input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                       output logic [7:0] rd, output bit err);
    logic [7:0] q[$];
    if (sid == 0) q = q0; else q = q1;
    rd = 8'h00;
    err = 1'b0;
    case (addr)
      2'd0: if (wr) begin
              if (q.size() == K) begin err = 1'b1; ovf[sid] = 1'b1; end
              else q.push_back(wd);
            end else if (q.size() > 0) rd = q[0];
      2'd1: if (wr) err = 1'b1;
            else if (q.size() == 0) begin err = 1'b1; udf[sid] = 1'b1; end
            else rd = q.pop_front();
      2'd2: if (wr) err = 1'b1;
            else rd = {udf[sid], ovf[sid], q.size() == K, q.size() == 0, 4'(q.size())};
      default: if (wr) begin
                 if (wd[0]) q.delete();
                 if (wd[1]) begin ovf[sid] = 1'b0; udf[sid] = 1'b0; end
               end
    endcase
    if (sid == 0) q0 = q; else q1 = q;
  endtask

  // Entered and left at posedge+1; leaves setup-ready so transfers can run back to back.
  task automatic bus(input int sid, input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd, output logic err, output int cyc);
    bit done = 1'b0;
    cur = (sid != 0);
    PSELx = (sid == 0) ? 2'b01 : 2'b10;
    PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    cyc = 2; rd = 8'h00; err = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (rdy_m) begin rd = rdata_m; err = err_m; done = 1'b1; end
      else cyc++;
      @(posedge PCLK); #1;
    end
    PSELx = 2'b00; PENABLE = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got no PREADY expected PREADY within 40 cycles");
    end
  endtask

  task automatic run(input int sid, input bit wr, input logic [1:0] addr, input logic [7:0] wd,
                     input string tag);
    logic [7:0] erd, rd;
    bit eerr;
    logic err;
    int cyc, n;
    model(sid, wr, addr, wd, erd, eerr);
    bus(sid, wr, addr, wd, rd, err, cyc);
    n = (sid == 0) ? q0.size() : q1.size();
    check({tag, "_prdata"}, rd, erd);
    check({tag, "_pslverr"}, err, eerr);
    check({tag, "_cycles"}, cyc, (sid == 0) ? 2 : 5);
    check({tag, "_count"}, count_m, n);
    check({tag, "_empty"}, empty_m, n == 0);
    check({tag, "_full"}, full_m, n == K);
    check({tag, "_irq"}, irq_m, n != 0);
  endtask

  initial begin
    logic [7:0] rd, erd, wd;
    logic err;
    bit eerr, wr;
    int cyc;
    logic [1:0] addr;

    tv[0]  = '{1'b1, 2'd0, 8'h11, 8'h00, 1'b0};
    tv[1]  = '{1'b1, 2'd0, 8'h22, 8'h00, 1'b0};
    tv[2]  = '{1'b1, 2'd0, 8'h33, 8'h00, 1'b0};
    tv[3]  = '{1'b0, 2'd2, 8'h00, 8'h03, 1'b0};
    tv[4]  = '{1'b0, 2'd1, 8'h00, 8'h11, 1'b0};
    tv[5]  = '{1'b0, 2'd1, 8'h00, 8'h22, 1'b0};
    tv[6]  = '{1'b0, 2'd1, 8'h00, 8'h33, 1'b0};
    tv[7]  = '{1'b0, 2'd2, 8'h00, 8'h10, 1'b0};
    tv[8]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    tv[9]  = '{1'b1, 2'd1, 8'h5A, 8'h00, 1'b1};
    tv[10] = '{1'b1, 2'd2, 8'hFF, 8'h00, 1'b1};
    tv[11] = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b0};
    tv[12] = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b1};
    tv[13] = '{1'b0, 2'd2, 8'h00, 8'h90, 1'b0};
    tv[14] = '{1'b1, 2'd3, 8'h02, 8'h00, 1'b0};

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready0", ready0, 1'b0);
    check("rst_prdata0", rdata0, 8'h00);
    check("rst_pslverr0", err0, 1'b0);
    check("rst_count0", count0, 4'd0);
    check("rst_empty0", empty0, 1'b1);
    check("rst_full0", full0, 1'b0);
    check("rst_irq0", irq0, 1'b0);
    check("rst_pready1", ready1, 1'b0);
    check("rst_empty1", empty1, 1'b1);
    @(posedge PCLK); #1;
    PRESET = 1'b1;

    for (int i = 0; i < 15; i++) begin
      model(0, tv[i].wr, tv[i].addr, tv[i].wd, erd, eerr);
      bus(0, tv[i].wr, tv[i].addr, tv[i].wd, rd, err, cyc);
      check($sformatf("vec%0d_prdata", i), rd, tv[i].exp_rd);
      check($sformatf("vec%0d_pslverr", i), err, tv[i].exp_err);
      check($sformatf("vec%0d_cycles", i), cyc, 2);
    end
    run(0, 1'b0, 2'd2, 8'h00, "vec_status_end");

    for (int i = 0; i < 9; i++) run(0, 1'b1, 2'd0, 8'(i + 1), $sformatf("fill%0d", i));
    bus(0, 1'b0, 2'd2, 8'h00, rd, err, cyc);
    check("full_status", rd, 8'h68);
    check("full_flag", full0, 1'b1);
    for (int i = 0; i < 9; i++) run(0, 1'b0, 2'd1, 8'h00, $sformatf("drain%0d", i));
    bus(0, 1'b0, 2'd2, 8'h00, rd, err, cyc);
    check("udf_bit", rd[7], 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) run(0, 1'b1, 2'd0, 8'($urandom), $sformatf("wrap%0d_push", r));
      for (int i = 0; i < 6; i++) run(0, 1'b0, 2'd1, 8'h00, $sformatf("wrap%0d_pop", r));
    end

    run(0, 1'b1, 2'd3, 8'h02, "ctrl_clr");
    for (int i = 0; i < 9; i++) run(0, 1'b1, 2'd0, 8'($urandom), "cf_fill");
    for (int i = 0; i < 4; i++) run(0, 1'b0, 2'd1, 8'h00, "cf_pop");
    run(0, 1'b1, 2'd3, 8'h03, "ctrl_flush");
    check("flush_count", count0, 4'd0);
    bus(0, 1'b0, 2'd2, 8'h00, rd, err, cyc);
    check("flush_status", rd, 8'h10);
    run(0, 1'b1, 2'd2, 8'hFF, "wr_status");

    for (int i = 0; i < 200; i++) begin
      addr = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      wd = 8'($urandom);
      if (addr == 2'd3) wd = {6'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0)};
      if (addr == 2'd0 && wr == 1'b0 && $urandom_range(0, 1) == 1) wr = 1'b1;
      run(0, wr, addr, wd, $sformatf("rnd%0d", i));
    end

    run(1, 1'b0, 2'd0, 8'h00, "ws_peek_empty");
    run(1, 1'b1, 2'd0, 8'hA5, "ws_push");
    run(1, 1'b0, 2'd0, 8'h00, "ws_peek");
    cur = 1'b1;
    PSELx = 2'b10; PADDR = 2'd1; PWRITE = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    check("abort_pready", ready1, 1'b0);
    @(posedge PCLK); #1;
    PSELx = 2'b00; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("abort_count", count1, 4'd1);
    run(1, 1'b0, 2'd2, 8'h00, "abort_status");
    run(1, 1'b0, 2'd1, 8'h00, "ws_pop");
    for (int i = 0; i < 10; i++)
      run(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 8'($urandom), $sformatf("ws_rnd%0d", i));

    run(0, 1'b1, 2'd0, 8'hC1, "rst_pre_push");
    run(0, 1'b1, 2'd0, 8'hC2, "rst_pre_push");
    cur = 1'b0;
    PSELx = 2'b01; PADDR = 2'd1; PWRITE = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b0;
    @(posedge PCLK); #1;
    check("midrst_pready", ready0, 1'b0);
    check("midrst_prdata", rdata0, 8'h00);
    check("midrst_pslverr", err0, 1'b0);
    check("midrst_count", count0, 4'd0);
    check("midrst_empty", empty0, 1'b1);
    check("midrst_full", full0, 1'b0);
    check("midrst_irq", irq0, 1'b0);
    check("midrst_count1", count1, 4'd0);
    PSELx = 2'b00; PENABLE = 1'b0; PRESET = 1'b1;
    q0.delete(); q1.delete();
    ovf[0] = 1'b0; ovf[1] = 1'b0; udf[0] = 1'b0; udf[1] = 1'b0;
    run(0, 1'b0, 2'd2, 8'h00, "post_rst_status");
    run(0, 1'b0, 2'd1, 8'h00, "post_rst_pop");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1);
  end
endmodule

// File: doc/apb_result_completer.md
# apb_result_completer

APB completer (slave) at the far end of the ALU's APB bridge: it accepts ALU result words written over APB into a K-deep FIFO and serves them back on reads. It also exposes a status/control register pair and a configurable number of wait states. It sits on the APB bus selected by one bit of PSELx, and it presents FIFO occupancy flags to local logic.

## Interface
- M, 8: data width (PWDATA/PRDATA); must be >= 8.
- K, 8: FIFO depth; power of two, 2..8.
- WAIT_STATES, 0: PREADY low cycles inserted in each access phase; 0..15.
- SLAVE_ID, 0: index of PSELx bit that selects this completer (0 or 1).

Ports:
- PCLK  input  1  single clock, all logic rising-edge.
- PRESET  input  1  synchronous, active-low reset.
- PADDR  input  2  register address.
- PSELx  input  2  APB selects; this block uses PSELx[SLAVE_ID] ("sel").
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  M  write data.
- PREADY  output  1  transfer completion.
- PRDATA  output  M  read data, valid only while PREADY=1 on a read.
- PSLVERR  output  1  error response, valid only while PREADY=1.
- o_count  output  4  FIFO occupancy 0..K.
- o_empty  output  1  o_count==0.
- o_full  output  1  o_count==K.
- o_irq  output  1  result available (= !o_empty).

## Operation
- Register map:
  - 0 DATA. Write pushes PWDATA. Read peeks the head without popping; returns 0 if empty.
  - 1 POP. Read returns head and pops. Write is illegal.
  - 2 STATUS, read-only: [3:0] count, [4] empty, [5] full, [6] overflow sticky, [7] underflow sticky, upper bits 0.
  - 3 CTRL. Write bit0=1 flushes FIFO (count->0, pointers->0); bit1=1 clears both sticky flags. Read returns 0.
- Errors (PSLVERR=1 on the completing cycle, no state change except as listed):
  - Write DATA when full: data dropped, overflow sticky set.
  - Read POP when empty: PRDATA=0, underflow sticky set.
  - Write to POP or STATUS: ignored.
- FSM, two states:
  - IDLE: PREADY=0. On sel && !PENABLE (setup phase), load wait counter with WAIT_STATES and go to ACCESS.
  - ACCESS: PREADY = (cnt==0). While cnt!=0, decrement. When sel && PENABLE && PREADY, commit the transfer on that edge and return to IDLE.
  - ACCESS with sel=0 (aborted transfer): return to IDLE with no side effect.
- Commit happens exactly once per transfer, at the PCLK edge where sel && PENABLE && PREADY are all 1. Addresses, data and direction are sampled at that edge.
- FIFO is circular with read/write pointers of log2(K) bits that wrap K-1 -> 0. o_count, o_full and o_empty are registered and update on the commit edge.
- CTRL write with both bits set performs flush and clear on the same edge.
- Back-to-back transfers: a new setup phase on the cycle after completion is accepted from IDLE normally.

## Timing
- Reset (PRESET=0 at a clock edge) forces:
  - state IDLE, PREADY=0, PRDATA=0, PSLVERR=0;
  - FIFO pointers and count 0, o_empty=1, o_full=0, o_irq=0;
  - stickies 0.
- Reset takes effect mid-transfer: any in-flight transfer is dropped without commit.
- Transfer length:
  - WAIT_STATES=0: setup cycle, then access cycle with PREADY=1, so 2 cycles.
  - WAIT_STATES=W: PREADY rises on access cycle W+1, so 2+W cycles total.
- PREADY, PRDATA and PSLVERR depend only on registered state plus the current PADDR/PWRITE. There is no combinational path from PENABLE to PREADY.
- PRDATA=0 and PSLVERR=0 whenever PREADY=0 or on writes.
- Pop read: PRDATA shows the pre-pop head. o_count decrements one cycle after the commit edge, i.e. registered at that edge.

## Test plan
- Reset, then write DATA 0x11, 0x22, 0x33 (W=0) -> each transfer 2 cycles, PSLVERR=0; STATUS reads 0x03; POP reads return 0x11, 0x22, 0x33; final STATUS 0x10.
- Write 9 words with K=8 -> 9th gets PSLVERR=1, o_full=1, STATUS=0x68; the 9 POP reads give words 1..8, then PRDATA=0, PSLVERR=1, and STATUS shows the underflow bit [7] set.
- Wrap-around: push 6 and pop 6, repeated 3 times with distinct data -> data order preserved across pointer wrap; o_count returns to 0 each round.
- WAIT_STATES=3: read DATA -> PREADY low for 3 access cycles, high on 4th; transfer is 5 cycles; deassert sel during wait -> no pop, FSM back to IDLE.
- CTRL write 0x03 with 4 entries and overflow set -> next cycle o_count=0, o_empty=1, STATUS=0x10; write to STATUS returns PSLVERR=1 with no change.
- Assert PRESET=0 during the access phase of a POP read -> no pop occurs, all outputs at reset values next cycle.
